// File: rtl/cpu_data_mem_responder.sv
// Memory-side responder for the CPU data port: one outstanding load/store,
// serviced after WAIT_CYCLES wait states, answered over a valid/ready handshake.
module cpu_data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              acc_go;
    logic              acc_wr;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;

    assign accept = req_valid & req_ready_q;

    // Zero-wait accesses use the live request; otherwise the captured copy.
    assign acc_wr    = (state_q == S_IDLE) ? req_write : wr_q;
    assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == S_IDLE) ? req_be    : be_q;

    assign acc_err = (acc_addr[1:0] != 2'b00) |
                     (acc_addr[31:ADDR_W+2] != '0);
    assign acc_idx = acc_addr[ADDR_W+1:2];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        acc_go       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    cnt_d       = WAIT_INIT;
                    req_ready_d = 1'b0;
                    if (WAIT_INIT == 4'd0) begin
                        acc_go  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (acc_go) begin
            resp_valid_d = 1'b1;
            err_d        = acc_err;
            rdata_d      = (!acc_err && !acc_wr) ? mem[acc_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Storage is never reset; acc_go is low while rst holds the FSM in idle.
    always_ff @(posedge clk) begin
        if (acc_go && acc_wr && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Self-checking bench: instance 0 uses two wait states, instance 1 uses none.
module tb_cpu_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    cpu_data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] rd;
        bit          er;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] rm  [2][256];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting on DUT", nm);
    endtask

    task automatic txn(input int s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input int stall, output logic [31:0] rd,
                       output logic er, output int lat);
        int n;
        n   = 0;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_write[s] = w;
        req_addr[s]  = a;
        req_wdata[s] = d;
        req_be[s]    = be;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            timeout("req_ready");
            req_valid[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        @(negedge clk);
        lat = 1;
        while (resp_valid[s] !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            timeout("resp_valid");
            return;
        end
        repeat (stall) @(negedge clk);
        rd = resp_rdata[s];
        er = resp_err[s];
        resp_ready[s] = 1'b1;
        @(posedge clk);
        #1 resp_ready[s] = 1'b0;
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    endfunction

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s]  = 1'b0;
            req_write[s]  = 1'b0;
            req_addr[s]   = '0;
            req_wdata[s]  = '0;
            req_be[s]     = '0;
            resp_ready[s] = 1'b0;
        end

        tbl[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        0};
        tbl[1]  = '{0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0};
        tbl[2]  = '{1, 32'h10,  32'h11223344, 4'h5, 32'h0,        0};
        tbl[3]  = '{0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 0};
        tbl[4]  = '{1, 32'h12,  32'h55555555, 4'hF, 32'h0,        1};
        tbl[5]  = '{1, 32'h400, 32'h66666666, 4'hF, 32'h0,        1};
        tbl[6]  = '{0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 0};
        tbl[7]  = '{1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        0};
        tbl[8]  = '{0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 0};
        tbl[9]  = '{0, 32'h13,  32'h0,        4'h0, 32'h0,        1};
        tbl[10] = '{1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        0};
        tbl[11] = '{0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 0};

        // Reset state, then req_ready rises one edge after release.
        #1;
        chk("rst_ready",  {31'd0, req_ready[0]},  32'd0);
        chk("rst_valid",  {31'd0, resp_valid[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_ready_low", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1 chk("rel_ready_high", {31'd0, req_ready[0]}, 32'd1);
        chk("rel_ready_high0", {31'd0, req_ready[1]}, 32'd1);

        // Async reset in the middle of a response cycle.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h12;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_resp_pending", {31'd0, resp_valid[0]}, 32'd1);
        chk("t1_err_pending",  {31'd0, resp_err[0]},   32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_ready", {31'd0, req_ready[0]},  32'd0);
        chk("t1_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("t1_rdata", resp_rdata[0],           32'd0);
        chk("t1_err",   {31'd0, resp_err[0]},   32'd0);
        chk("t1_ready0", {31'd0, req_ready[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("t1_ready_back", {31'd0, req_ready[0]}, 32'd1);

        // Table vectors on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                txn(s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, i % 3,
                    rd, er, lat);
                chk($sformatf("tbl%0d_%0d_rdata", s, i), rd, tbl[i].rd);
                chk($sformatf("tbl%0d_%0d_err", s, i), {31'd0, er},
                    {31'd0, tbl[i].er});
                chk($sformatf("tbl%0d_%0d_lat", s, i), lat,
                    (s == 0) ? 32'd3 : 32'd1);
            end
        end

        // Held response with a concurrent request that must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("t4_ready");
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("t4_valid");
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_wdata[0] = 32'h0;
        req_be[0]    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, resp_valid[0]}, 32'd1);
            chk("t4_hold_rdata", resp_rdata[0], 32'hDE22BE44);
            chk("t4_hold_err",   {31'd0, resp_err[0]}, 32'd0);
            chk("t4_hold_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;
        chk("t4_hs_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("t4_hs_rdata", resp_rdata[0], 32'd0);
        chk("t4_hs_err",   {31'd0, resp_err[0]}, 32'd0);
        chk("t4_hs_ready", {31'd0, req_ready[0]}, 32'd1);
        txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t4_reload", rd, 32'hDE22BE44);

        // Reset during the first wait cycle discards the pending store.
        txn(0, 1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'hCAFEF00D;
        req_be[0]    = 4'hF;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("t6_ready");
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_resp", {31'd0, resp_valid[0]}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_resp_after", {31'd0, resp_valid[0]}, 32'd0);
        end
        txn(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6_kept_old", rd, 32'h11111111);

        // Zero-wait instance: the store lands at acceptance and survives reset.
        txn(1, 1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hCAFEF00D;
        req_be[1]    = 4'hF;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("t6z_ready");
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        #3 rst = 1'b1;
        #1 chk("t6z_valid_cleared", {31'd0, resp_valid[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        chk("t6z_retained", rd, 32'hCAFEF00D);

        // Random traffic against an array model, words 64..79 only.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                rm[s][64+k] = $urandom;
                txn(s, 1, 32'h100 + 32'(4*k), rm[s][64+k], 4'hF, 0,
                    rd, er, lat);
            end
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a, d, exp_rd;
                logic [3:0]  be;
                bit          w, e;
                int          sel;
                sel = $urandom_range(0, 9);
                a   = 32'h100 + 32'(4 * $urandom_range(0, 15));
                if (sel == 0) a = a + 32'($urandom_range(1, 3));
                if (sel == 1) a = a | 32'h400;
                w   = 1'($urandom_range(0, 1));
                d   = $urandom;
                be  = 4'($urandom_range(0, 15));
                e   = addr_err(a);
                exp_rd = 32'd0;
                if (!e && !w) exp_rd = rm[s][a[9:2]];
                if (!e && w) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) rm[s][a[9:2]][8*b +: 8] = d[8*b +: 8];
                end
                txn(s, w, a, d, be, $urandom_range(0, 3), rd, er, lat);
                chk($sformatf("rnd%0d_%0d_rdata", s, i), rd, exp_rd);
                chk($sformatf("rnd%0d_%0d_err", s, i), {31'd0, er},
                    {31'd0, e});
                chk($sformatf("rnd%0d_%0d_lat", s, i), lat,
                    (s == 0) ? 32'd3 : 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
